rl_ram_1rw_req_ctrl: RTL and testbench
======================================

Name: rl_ram_1rw_req_ctrl

Overview:
Request-side controller that drives the port of a single-port (1RW) RAM macro from a valid/ready request stream and returns read data on a valid/ready response stream.
- Hides the RAM's fixed 1-cycle, unregistered read latency.
- Absorbs response back-pressure with a small credit-protected response buffer.
- Sits between a bus/CPU-side agent and any rl_ram_1rw_* technology wrapper.

Parameters:
- ABITS, 10, address width (RAM depth = 2**ABITS words).
- DBITS, 32, data width.
- RSP_DEPTH, 2, response buffer entries; power of 2, >=2.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ABITS  word address.
- req_be  input  (DBITS+7)/8  byte enables (writes only).
- req_din  input  DBITS  write data.
- rsp_valid  output  1  read data present.
- rsp_ready  input  1  consumer takes read data.
- rsp_dout  output  DBITS  read data.
- mem_addr  output  ABITS  to RAM addr.
- mem_we  output  1  to RAM we.
- mem_be  output  (DBITS+7)/8  to RAM be.
- mem_din  output  DBITS  to RAM din.
- mem_dout  input  DBITS  from RAM dout; valid the cycle after a read is sampled.

Behaviour:
- Reset (rstn low, async): rd_pending=0, buffer empty, rsp_valid=0, mem_we=0, req_ready=1 once released.
- accept = req_valid & req_ready. req_ready depends only on internal state, never on req_*: req_ready = (fifo_cnt + rd_pending) < RSP_DEPTH. Writes are also stalled when no credit remains.
- RAM drive (combinational): mem_addr=req_addr, mem_din=req_din, mem_be=req_be, mem_we=accept & req_we. Non-accepted cycles present harmless reads.
- Writes are posted: no response, no credit consumed.
- Read accepted in cycle N: rd_pending=1 in cycle N+1, when mem_dout holds the data.
- Response path in cycle N+1:
  - Buffer empty: bypass. rsp_valid=1 and rsp_dout=mem_dout. If rsp_ready=1, the response is consumed. If rsp_ready=0, mem_dout is pushed into the buffer at end of N+1.
  - Buffer non-empty: mem_dout is always pushed. rsp_valid=1 and rsp_dout=buffer head; pop on rsp_ready.
- Ordering: responses are returned strictly in request order.
- Throughput: back-to-back reads give 1 response/cycle with rsp_ready held high. Minimum read latency is 1 cycle.
- Credit rule: push and pop may occur in the same cycle. The buffer must never overflow: a push with fifo_cnt==RSP_DEPTH is an assertion failure.
- Pointers: RSP_DEPTH is a power of 2, so wr/rd pointers are log2(RSP_DEPTH) bits and wrap naturally. fifo_cnt is log2(RSP_DEPTH)+1 bits.
- Reset mid-operation: in-flight read and buffered data are discarded. No response is emitted after rstn deasserts.
- Handshake stability: once rsp_valid=1, rsp_dout holds until rsp_ready.

Decomposition:
- Package rl_ram_pkg: function for log2 of RSP_DEPTH and a request struct type {we, addr, be, din} parameterised by localparams.
- One sub-module: rl_ram_rsp_fifo.
  - Ports: clk, rstn, push, din, pop, dout, empty, cnt.
  - Pointer/count-based, RSP_DEPTH entries.
- Top handles credit, rd_pending and bypass mux.

Test Plan:
- Write 0xDEADBEEF to addr 0x005 (be=4'hF), then read 0x005 with rsp_ready=1 -> rsp_valid exactly 1 cycle after read accept; rsp_dout=0xDEADBEEF; mem_we high only in write-accept cycle.
- Partial write be=4'b0010 data 0x0000AB00 over 0xDEADBEEF at 0x005, read back -> 0xDEADABEF.
- 8 back-to-back reads of addrs 0..7 (preloaded with addr*0x11), rsp_ready=1 -> 8 consecutive rsp_valid cycles, data 0x00..0x77 in order; req_ready never drops.
- rsp_ready=0, issue reads to 1,2,3 -> only 2 accepted (RSP_DEPTH=2); req_ready=0 from the cycle after 2nd accept. Raise rsp_ready -> 0x11, 0x22, then 3rd read accepted and 0x33 returned.
- Assert rstn low while 1 read pending and 1 buffered -> rsp_valid=0 immediately (async); after release req_ready=1, no stale response.
- Random mix of reads/writes with random rsp_ready vs. scoreboard model, 10k transactions -> zero mismatches, no overflow assertion.

Source files
------------

// File: rtl/rl_ram_pkg.sv
// ---------------------------------------------------------------------------
// rl_ram_pkg
// Shared definitions for the rl_ram_* request-side blocks.
//   - log2_ceil : constant function that sizes pointers and counters
//                 from a buffer depth.
//   - rl_ram_req_t : one RAM request {we, addr, be, din} at the default
//                 macro geometry (RL_ABITS x RL_DBITS).
// ---------------------------------------------------------------------------
package rl_ram_pkg;

  localparam int RL_ABITS  = 10;
  localparam int RL_DBITS  = 32;
  localparam int RL_BEBITS = (RL_DBITS + 7) / 8;

  typedef struct packed {
    logic                 we;
    logic [RL_ABITS-1:0]  addr;
    logic [RL_BEBITS-1:0] be;
    logic [RL_DBITS-1:0]  din;
  } rl_ram_req_t;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rl_ram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// rl_ram_rsp_fifo
// Small pointer/count response buffer holding read data that the consumer
// could not take yet. Depth is a power of two so the pointers wrap on
// their own.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   push, din  write one word at the tail
//   pop        remove the head word (ignored while empty)
//   dout       head word (meaningful only while !empty)
//   empty      no words stored
//   cnt        number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module rl_ram_rsp_fifo
  import rl_ram_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DBITS = 32,
  localparam int PW   = log2_ceil(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [DBITS-1:0] din,
  input  logic             pop,
  output logic [DBITS-1:0] dout,
  output logic             empty,
  output logic [PW:0]      cnt
);

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             pop_eff;

  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_eff = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop_eff);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: a word is only ever read after it was pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // The credit scheme upstream must make a push into a full buffer impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
                                   !(push && (cnt_q == (PW+1)'(DEPTH))));

endmodule

// File: rtl/rl_ram_1rw_req_ctrl.sv
// ---------------------------------------------------------------------------
// rl_ram_1rw_req_ctrl
// Drives a single-port RAM macro from a valid/ready request stream and
// returns read data on a valid/ready response stream. The RAM's 1-cycle
// unregistered read latency is hidden by tracking one pending read and
// bypassing its data straight to the response port; back-pressure is
// absorbed by a credit-protected response buffer.
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we/req_addr/req_be/req_din  request payload (be/din for writes)
//   rsp_valid/rsp_ready/rsp_dout    read-response handshake and data
//   mem_addr/mem_we/mem_be/mem_din  RAM port drive
//   mem_dout                        RAM read data, one cycle after the read
// ---------------------------------------------------------------------------
module rl_ram_1rw_req_ctrl
  import rl_ram_pkg::*;
#(
  parameter int ABITS     = 10,
  parameter int DBITS     = 32,
  parameter int RSP_DEPTH = 2,
  localparam int BEBITS   = (DBITS + 7) / 8,
  localparam int PW       = log2_ceil(RSP_DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ABITS-1:0]  req_addr,
  input  logic [BEBITS-1:0] req_be,
  input  logic [DBITS-1:0]  req_din,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DBITS-1:0]  rsp_dout,
  output logic [ABITS-1:0]  mem_addr,
  output logic              mem_we,
  output logic [BEBITS-1:0] mem_be,
  output logic [DBITS-1:0]  mem_din,
  input  logic [DBITS-1:0]  mem_dout
);

  logic             accept;
  logic             rd_pending_q, rd_pending_d;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [PW:0]      fifo_cnt;
  logic [DBITS-1:0] fifo_dout;
  logic [PW+1:0]    credits_used;

  // Every read accepted but not yet handed out holds one buffer slot, so
  // the buffer can always absorb the pending read even if the consumer
  // stalls. Writes are stalled too, keeping req_ready independent of req_*.
  assign credits_used = {1'b0, fifo_cnt} + (PW+2)'(rd_pending_q);
  assign req_ready    = (credits_used < (PW+2)'(RSP_DEPTH));
  assign accept       = req_valid & req_ready;

  // The RAM sees the request directly; a non-accepted cycle is just a
  // harmless read whose data nobody looks at.
  assign mem_addr = req_addr;
  assign mem_din  = req_din;
  assign mem_be   = req_be;
  assign mem_we   = accept & req_we;

  assign rd_pending_d = accept & ~req_we;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= rd_pending_d;
    end
  end

  // With the buffer empty the pending read's data goes straight out and is
  // parked only if the consumer stalls. Once the buffer holds anything, new
  // data must queue behind it to keep responses in request order.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_dout  = mem_dout;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (fifo_empty) begin
      rsp_valid = rd_pending_q;
      rsp_dout  = mem_dout;
      fifo_push = rd_pending_q & ~rsp_ready;
    end else begin
      rsp_valid = 1'b1;
      rsp_dout  = fifo_dout;
      fifo_push = rd_pending_q;
      fifo_pop  = rsp_ready;
    end
  end

  rl_ram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .DBITS (DBITS)
  ) u_rsp_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   (mem_dout),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

endmodule

// File: tb/tb_rl_ram_1rw_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rl_ram_1rw_req_ctrl
// Self-checking bench: a behavioural RAM macro on the mem_* port, a
// queue-based reference model of outstanding reads, a per-cycle compare
// process, directed scenarios with literal expectations and a random phase.
// ---------------------------------------------------------------------------
module tb_rl_ram_1rw_req_ctrl;

  localparam int ABITS     = 10;
  localparam int DBITS     = 32;
  localparam int RSP_DEPTH = 2;
  localparam int BEBITS    = (DBITS + 7) / 8;
  localparam int NUM_TXN   = 10000;
  localparam int MAX_CYC   = 60000;

  logic              clk;
  logic              rstn;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ABITS-1:0]  req_addr;
  logic [BEBITS-1:0] req_be;
  logic [DBITS-1:0]  req_din;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DBITS-1:0]  rsp_dout;
  logic [ABITS-1:0]  mem_addr;
  logic              mem_we;
  logic [BEBITS-1:0] mem_be;
  logic [DBITS-1:0]  mem_din;
  logic [DBITS-1:0]  mem_dout;

  int checks;
  int errors;
  int acc_cnt;

  logic [DBITS-1:0] ram    [2**ABITS];
  logic [DBITS-1:0] shadow [2**ABITS];
  logic [DBITS-1:0] exp_q  [$];

  rl_ram_1rw_req_ctrl #(
    .ABITS     (ABITS),
    .DBITS     (DBITS),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_din   (req_din),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dout  (rsp_dout),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM macro: address sampled at the edge, data visible the next cycle.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BEBITS; b++) begin
        if (mem_be[b]) begin
          ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
      end
    end
    mem_dout <= ram[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [DBITS-1:0] act,
                             input logic [DBITS-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we,
                               input logic [ABITS-1:0] addr,
                               input logic [BEBITS-1:0] be,
                               input logic [DBITS-1:0] din, input logic rr);
    @(posedge clk);
    #1;
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_din   = din;
    rsp_ready = rr;
  endtask

  // Reference model: every read accepted and not yet consumed is one queue
  // entry, holding the word the memory contained when the read was taken.
  initial begin
    acc_cnt = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        exp_q.delete();
      end else begin
        logic ready_now;
        ready_now = (exp_q.size() < RSP_DEPTH);
        if (exp_q.size() > 0 && rsp_ready) begin
          void'(exp_q.pop_front());
        end
        if (req_valid && ready_now) begin
          acc_cnt = acc_cnt + 1;
          if (req_we) begin
            for (int b = 0; b < BEBITS; b++) begin
              if (req_be[b]) begin
                shadow[req_addr][8*b +: 8] = req_din[8*b +: 8];
              end
            end
          end else begin
            exp_q.push_back(shadow[req_addr]);
          end
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        checkOutput("rsp_valid_in_reset", {31'b0, rsp_valid}, '0);
      end else begin
        logic exp_ready;
        exp_ready = (exp_q.size() < RSP_DEPTH);
        checkOutput("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
        checkOutput("rsp_valid", {31'b0, rsp_valid}, {31'b0, (exp_q.size() > 0)});
        if (exp_q.size() > 0) begin
          checkOutput("rsp_dout", rsp_dout, exp_q[0]);
        end
        checkOutput("mem_we", {31'b0, mem_we},
                    {31'b0, (req_valid & exp_ready & req_we)});
        checkOutput("mem_addr", {22'b0, mem_addr}, {22'b0, req_addr});
        if (mem_we) begin
          checkOutput("mem_din", mem_din, req_din);
          checkOutput("mem_be", {28'b0, mem_be}, {28'b0, req_be});
        end
      end
    end
  end

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2**ABITS; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_din   = '0;
    rsp_ready = 1'b1;

    #3;
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    checkOutput("post_reset_req_ready", {31'b0, req_ready}, 32'd1);

    // Full write then read back with latency 1.
    applyStimulus(1'b1, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF, 1'b1);
    #1 checkOutput("wr_mem_we", {31'b0, mem_we}, 32'd1);
    applyStimulus(1'b1, 1'b0, 10'h005, 4'h0, 32'h0, 1'b1);
    #1 checkOutput("rd_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rd_no_early_rsp", {31'b0, rsp_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b1);
    #1 checkOutput("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("rd_rsp_dout", rsp_dout, 32'hDEADBEEF);
    checkOutput("idle_mem_we", {31'b0, mem_we}, 32'd0);
    applyStimulus(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b1);
    #1 checkOutput("rd_single_rsp", {31'b0, rsp_valid}, 32'd0);

    // Partial byte-enable write.
    applyStimulus(1'b1, 1'b1, 10'h005, 4'b0010, 32'h0000AB00, 1'b1);
    applyStimulus(1'b1, 1'b0, 10'h005, 4'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b1);
    #1 checkOutput("be_rsp_dout", rsp_dout, 32'hDEADABEF);

    // Preload 0..7 with addr*0x11, then 8 back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, ABITS'(i), 4'hF, 32'(i * 32'h11), 1'b1);
    end
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        applyStimulus(1'b1, 1'b0, ABITS'(i), 4'h0, 32'h0, 1'b1);
      end else begin
        applyStimulus(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b1);
      end
      #1;
      if (i < 8) begin
        checkOutput("b2b_req_ready", {31'b0, req_ready}, 32'd1);
      end
      if (i > 0) begin
        checkOutput("b2b_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        checkOutput("b2b_rsp_dout", rsp_dout, 32'((i - 1) * 32'h11));
      end
    end

    // Back-pressure: only RSP_DEPTH reads outstanding.
    applyStimulus(1'b1, 1'b0, 10'h001, 4'h0, 32'h0, 1'b0);
    #1 checkOutput("bp_a_ready", {31'b0, req_ready}, 32'd1);
    applyStimulus(1'b1, 1'b0, 10'h002, 4'h0, 32'h0, 1'b0);
    #1 checkOutput("bp_b_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("bp_b_dout", rsp_dout, 32'h11);
    applyStimulus(1'b1, 1'b0, 10'h003, 4'h0, 32'h0, 1'b0);
    #1 checkOutput("bp_c_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("bp_c_dout", rsp_dout, 32'h11);
    applyStimulus(1'b1, 1'b0, 10'h003, 4'h0, 32'h0, 1'b0);
    #1 checkOutput("bp_d_ready", {31'b0, req_ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'h003, 4'h0, 32'h0, 1'b1);
    #1 checkOutput("bp_e_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("bp_e_dout", rsp_dout, 32'h11);
    applyStimulus(1'b1, 1'b0, 10'h003, 4'h0, 32'h0, 1'b1);
    #1 checkOutput("bp_f_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("bp_f_dout", rsp_dout, 32'h22);
    applyStimulus(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b1);
    #1 checkOutput("bp_g_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("bp_g_dout", rsp_dout, 32'h33);
    applyStimulus(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b1);
    #1 checkOutput("bp_h_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset with one read pending and one buffered.
    applyStimulus(1'b1, 1'b0, 10'h001, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'h002, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b0);
    #1 checkOutput("rst_pre_valid", {31'b0, rsp_valid}, 32'd1);
    #1 rstn = 1'b0;
    #1 checkOutput("rst_async_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    #1 checkOutput("rst_release_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b1);
      #1 checkOutput("rst_no_stale", {31'b0, rsp_valid}, 32'd0);
    end

    // Random mix of reads and writes against the model.
    acc_cnt = 0;
    cyc     = 0;
    while (acc_cnt < NUM_TXN && cyc < MAX_CYC) begin
      applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
                    ABITS'($urandom_range(0, 63)), BEBITS'($urandom),
                    $urandom, ($urandom_range(0, 9) < 6));
      cyc = cyc + 1;
    end
    if (acc_cnt < NUM_TXN) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL random_budget: got %0d accepted, expected %0d", acc_cnt, NUM_TXN);
    end

    // Drain and confirm nothing is left.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b1);
    end
    #1 checkOutput("drain_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("drain_req_ready", {31'b0, req_ready}, 32'd1);

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
